// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transmit-path types and constants
package usb_pkg;

  // Bit stuffer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STUFF = 2'd2
  } bstuff_state_t;

  // USB inserts a 0 after six consecutive transmitted 1s
  localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - generic up/down counter with synchronous clear
module counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             inc_cnt,
  input  logic             clr_cnt,
  input  logic             up,
  output logic [CNT_W-1:0] cnt
);

  // Clear has priority over counting; up selects the count direction
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (inc_cnt) begin
      if (up) cnt <= cnt + 1'b1;
      else    cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bit_stuff.sv
// rtl/bit_stuff.sv - USB transmit bit stuffer (optional stuff_count via BIT_STUFF_STATS_EN)
module bit_stuff
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       inb,
  input  logic       recving,
  input  logic       pause_out,
  output logic       pause_in,
  output logic       outb,
  output logic       sending
`ifdef BIT_STUFF_STATS_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  bstuff_state_t    state;
  bstuff_state_t    next_state;
  logic [CNT_W-1:0] ones_cnt;
  logic             inc_cnt;
  logic             clr_cnt;
  logic             accept;
  logic             hit;

  // An upstream bit is consumed only when it is valid and downstream is not stalling
  assign accept = recving & ~pause_out;

  // Accepting this 1 brings the run of ones up to the stuffing length
  assign hit = inb & (ones_cnt == CNT_W'(STUFF_LEN - 1));

  counter #(.CNT_W(CNT_W)) u_ones_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (inc_cnt),
    .clr_cnt (clr_cnt),
    .up      (1'b1),
    .cnt     (ones_cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a stuff bit is owed even if the packet ends on the last 1
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = hit ? STUFF : PASS;
      end
      PASS: begin
        if (!pause_out) begin
          if (recving) next_state = hit ? STUFF : PASS;
          else         next_state = IDLE;
        end
      end
      STUFF: begin
        if (!pause_out) next_state = recving ? PASS : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output and ones-counter control; data passes through combinationally
  always_comb begin
    outb     = 1'b0;
    sending  = 1'b0;
    pause_in = 1'b0;
    inc_cnt  = 1'b0;
    clr_cnt  = 1'b0;
    case (state)
      IDLE: begin
        outb     = inb;
        sending  = recving;
        pause_in = pause_out;
        inc_cnt  = accept & inb;
        clr_cnt  = ~(accept & inb);
      end
      PASS: begin
        outb     = inb;
        sending  = recving;
        pause_in = pause_out;
        inc_cnt  = accept & inb;
        clr_cnt  = (accept & ~inb) | (~pause_out & ~recving);
      end
      STUFF: begin
        // Upstream holds its bit while the inserted 0 goes out
        outb     = 1'b0;
        sending  = 1'b1;
        pause_in = 1'b1;
        clr_cnt  = ~pause_out;
      end
      default: begin
        clr_cnt = 1'b1;
      end
    endcase
  end

`ifdef BIT_STUFF_STATS_EN
  // Per-packet count of completed stuff bits, saturating, held after packet end
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stuff_count <= 8'd0;
    end else if (state == IDLE && accept) begin
      stuff_count <= 8'd0;
    end else if (state == STUFF && !pause_out && stuff_count != 8'hFF) begin
      stuff_count <= stuff_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit_stuff.sv
// tb/tb_bit_stuff.sv - directed self-checking bench for bit_stuff
module tb_bit_stuff;
  import usb_pkg::*;

  logic clk;
  logic rst_L;
  logic inb;
  logic recving;
  logic pause_out;
  logic pause_in;
  logic outb;
  logic sending;
`ifdef BIT_STUFF_STATS_EN
  logic [7:0] stuff_count;
`endif

  int n_checks;
  int n_fail;

  bit_stuff dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .inb         (inb),
    .recving     (recving),
    .pause_out   (pause_out),
    .pause_in    (pause_in),
    .outb        (outb),
    .sending     (sending)
`ifdef BIT_STUFF_STATS_EN
    ,
    .stuff_count (stuff_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_L = 1'b0; inb = 1'b0; recving = 1'b0; pause_out = 1'b0;
    #1;
    n_checks++; if (outb !== 1'b0) begin n_fail++; $display("FAIL reset_outb got %b want 0", outb); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL reset_sending got %b want 0", sending); end
    n_checks++; if (pause_in !== 1'b0) begin n_fail++; $display("FAIL reset_pause_in got %b want 0", pause_in); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    @(posedge clk); #1;
    rst_L = 1'b1;
    // drive into STUFF then reset asynchronously mid-stuff
    for (int i = 0; i < 6; i++) begin
      inb = 1'b1; recving = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (dut.state !== STUFF) begin n_fail++; $display("FAIL pre_reset_state got %0d want STUFF", dut.state); end
    n_checks++; if (dut.ones_cnt !== 3'd6) begin n_fail++; $display("FAIL pre_reset_cnt got %0d want 6", dut.ones_cnt); end
    rst_L = 1'b0;
    #1;
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL async_reset_state got %0d want IDLE", dut.state); end
    n_checks++; if (dut.ones_cnt !== 3'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d want 0", dut.ones_cnt); end
    recving = 1'b0; inb = 1'b0;
    @(posedge clk); #1;
    rst_L = 1'b1;
  endtask

  task automatic test_stuff7();
    logic [7:0] e_out;
    logic [7:0] e_pin;
    e_out = 8'b11111101;
    e_pin = 8'b00000010;
    for (int i = 0; i < 8; i++) begin
      inb = 1'b1; recving = 1'b1; pause_out = 1'b0;
      @(negedge clk);
      n_checks++; if (outb !== e_out[7-i]) begin n_fail++; $display("FAIL stuff7_outb cyc %0d got %b want %b", i+1, outb, e_out[7-i]); end
      n_checks++; if (sending !== 1'b1) begin n_fail++; $display("FAIL stuff7_sending cyc %0d got %b want 1", i+1, sending); end
      n_checks++; if (pause_in !== e_pin[7-i]) begin n_fail++; $display("FAIL stuff7_pause_in cyc %0d got %b want %b", i+1, pause_in, e_pin[7-i]); end
      @(posedge clk); #1;
    end
    inb = 1'b0; recving = 1'b0;
    @(negedge clk);
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL stuff7_end_sending got %b want 0", sending); end
    @(posedge clk); #1;
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL stuff7_end_state got %0d want IDLE", dut.state); end
  endtask

  task automatic test_no_stuff();
    logic [10:0] stream;
    stream = 11'b11111011111;
    for (int i = 0; i < 11; i++) begin
      inb = stream[10-i]; recving = 1'b1; pause_out = 1'b0;
      @(negedge clk);
      n_checks++; if (outb !== stream[10-i]) begin n_fail++; $display("FAIL nostuff_outb cyc %0d got %b want %b", i+1, outb, stream[10-i]); end
      n_checks++; if (pause_in !== 1'b0) begin n_fail++; $display("FAIL nostuff_pause_in cyc %0d got %b want 0", i+1, pause_in); end
      @(posedge clk); #1;
    end
    n_checks++; if (dut.ones_cnt !== 3'd5) begin n_fail++; $display("FAIL nostuff_cnt got %0d want 5", dut.ones_cnt); end
    inb = 1'b0; recving = 1'b0;
    @(negedge clk);
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL nostuff_end_sending got %b want 0", sending); end
    @(posedge clk); #1;
  endtask

  task automatic test_end_after_six();
    for (int i = 0; i < 6; i++) begin
      inb = 1'b1; recving = 1'b1; pause_out = 1'b0;
      @(posedge clk); #1;
    end
    inb = 1'b0; recving = 1'b0;
    @(negedge clk);
    n_checks++; if (outb !== 1'b0) begin n_fail++; $display("FAIL end6_outb got %b want 0", outb); end
    n_checks++; if (sending !== 1'b1) begin n_fail++; $display("FAIL end6_sending got %b want 1", sending); end
    n_checks++; if (pause_in !== 1'b1) begin n_fail++; $display("FAIL end6_pause_in got %b want 1", pause_in); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL end6_after_sending got %b want 0", sending); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL end6_after_state got %0d want IDLE", dut.state); end
    n_checks++; if (dut.ones_cnt !== 3'd0) begin n_fail++; $display("FAIL end6_after_cnt got %0d want 0", dut.ones_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_pause();
    logic [10:0] v_in;
    logic [10:0] v_po;
    logic [10:0] e_out;
    logic [10:0] e_pin;
    v_in  = 11'b11111111110;
    v_po  = 11'b00011100000;
    e_out = 11'b11111111100;
    e_pin = 11'b00011100010;
    for (int i = 0; i < 11; i++) begin
      inb = v_in[10-i]; recving = 1'b1; pause_out = v_po[10-i];
      @(negedge clk);
      n_checks++; if (outb !== e_out[10-i]) begin n_fail++; $display("FAIL pause_outb cyc %0d got %b want %b", i+1, outb, e_out[10-i]); end
      n_checks++; if (pause_in !== e_pin[10-i]) begin n_fail++; $display("FAIL pause_pause_in cyc %0d got %b want %b", i+1, pause_in, e_pin[10-i]); end
      if (i >= 3 && i <= 5) begin
        n_checks++; if (dut.ones_cnt !== 3'd3) begin n_fail++; $display("FAIL pause_frozen_cnt cyc %0d got %0d want 3", i+1, dut.ones_cnt); end
      end
      @(posedge clk); #1;
    end
    inb = 1'b0; recving = 1'b0; pause_out = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL pause_end_state got %0d want IDLE", dut.state); end
  endtask

`ifdef BIT_STUFF_STATS_EN
  task automatic test_stats();
    logic [15:0] e_pin;
    e_pin = 16'b0000001000000100;
    for (int i = 0; i < 16; i++) begin
      inb = 1'b1; recving = 1'b1; pause_out = 1'b0;
      @(negedge clk);
      n_checks++; if (pause_in !== e_pin[15-i]) begin n_fail++; $display("FAIL stats_pause_in cyc %0d got %b want %b", i+1, pause_in, e_pin[15-i]); end
      @(posedge clk); #1;
    end
    inb = 1'b0; recving = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (stuff_count !== 8'd2) begin n_fail++; $display("FAIL stats_count got %0d want 2", stuff_count); end
    inb = 1'b0; recving = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (stuff_count !== 8'd0) begin n_fail++; $display("FAIL stats_clear got %0d want 0", stuff_count); end
    recving = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stuff7();
    test_no_stuff();
    test_end_after_six();
    test_pause();
`ifdef BIT_STUFF_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
